// File: rtl/load_align_unit.sv
// load_align_unit
// ---------------
// Load alignment stage between MEM and WB. It takes one load descriptor
// (byte offset, access size, signedness), consumes one memory read beat,
// or two when the access crosses a bus word, and extracts the addressed
// bytes. It then sign- or zero-extends them and hands the result to WB.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where valid and ready are both 1. A producer holds valid, and its
// payload stable, until that edge. The unit's ready/valid outputs are decoded
// from the FSM state only, so they never depend combinationally on inputs.
//
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   flush            drops any load in flight (state -> IDLE next cycle)
//   req_*            load descriptor channel (valid/ready, off/size/unsigned)
//   mem_*            memory read-beat channel (valid/ready, rdata)
//   wb_*             result channel (valid/ready, data, err)
//   dbg_state_o      current FSM state, exported for checkers
module load_align_unit #(
  parameter  int DATA_W      = 32,
  parameter  int MISALIGN_EN = 1,
  localparam int BYTES       = DATA_W / 8,
  localparam int OFF_W       = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LO = 2'd1,
    S_WAIT_HI = 2'd2,
    S_OUT     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               cross_q, cross_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               wb_err_q, wb_err_d;

  // Descriptor decode
  int                 req_end;
  logic               req_cross;
  logic               req_illegal;

  always_comb begin
    req_end     = int'(req_off) + (1 << req_size);
    req_cross   = (req_end > BYTES);
    // A dword access only exists on a 64-bit bus.
    req_illegal = (req_size == 2'd3) && (DATA_W < 64);
  end

  // Alignment datapath.
  // In WAIT_HI, the low beat sits in lo_q and the incoming beat is the high
  // half. In WAIT_LO, only the incoming beat matters. Shifting the
  // concatenation right by off*8 brings the first addressed byte to bit 0.
  logic [2*DATA_W-1:0] cat;
  logic [OFF_W+2:0]    sh_amt;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   ext_data;
  logic                sign;
  int                  nbits;

  always_comb begin
    cat      = (state_q == S_WAIT_HI) ? {mem_rdata, lo_q}
                                      : {{DATA_W{1'b0}}, mem_rdata};
    sh_amt   = {off_q, 3'b000};
    raw      = DATA_W'(cat >> sh_amt);
    ext_data = raw;
    nbits    = 8 << size_q;
    if (nbits > DATA_W) begin
      nbits = DATA_W;
    end
    case (size_q)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[DATA_W-1];
    endcase
    // Bits above the access length are replaced by the fill value. A
    // full-width access has no such bits, so it passes through unchanged.
    for (int i = 8; i < DATA_W; i++) begin
      if (i >= nbits) begin
        ext_data[i] = sign & ~uns_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    cross_d   = cross_q;
    lo_d      = lo_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;

    if (flush) begin
      // Flush beats any descriptor offered in the same cycle. wb_data is
      // deliberately left untouched.
      state_d = S_IDLE;
      lo_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            off_d   = req_off;
            size_d  = req_size;
            uns_d   = req_unsigned;
            cross_d = req_cross;
            if (req_illegal || (req_cross && (MISALIGN_EN == 0))) begin
              // Error response: no memory beat is consumed.
              wb_err_d  = 1'b1;
              wb_data_d = '0;
              state_d   = S_OUT;
            end else begin
              state_d = S_WAIT_LO;
            end
          end
        end
        S_WAIT_LO: begin
          if (mem_valid) begin
            lo_d = mem_rdata;
            if (cross_q) begin
              state_d = S_WAIT_HI;
            end else begin
              wb_data_d = ext_data;
              wb_err_d  = 1'b0;
              state_d   = S_OUT;
            end
          end
        end
        S_WAIT_HI: begin
          if (mem_valid) begin
            wb_data_d = ext_data;
            wb_err_d  = 1'b0;
            state_d   = S_OUT;
          end
        end
        S_OUT: begin
          if (wb_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      cross_q   <= 1'b0;
      lo_q      <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      cross_q   <= cross_d;
      lo_q      <= lo_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  // Outputs
  assign req_ready   = (state_q == S_IDLE);
  assign mem_ready   = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
  assign wb_valid    = (state_q == S_OUT);
  assign wb_data     = wb_data_q;
  assign wb_err      = wb_err_q;
  assign dbg_state_o = state_q;

endmodule
